param_shift_ring_cntr: RTL
==========================

# param_shift_ring_cntr

Parametrised shift-register counter, the WIDTH-generic successor of the fixed 4-bit ring counter. It runs as a ring (one-hot) counter or a Johnson (twisted-ring) counter, selectable at run time, and shifts in either direction. It supports synchronous parallel load and self-corrects illegal states. It serves as a phase or sequence generator feeding timing and sequencing logic, and reports wrap, error and position alongside the raw count.

## Interface
- WIDTH, 4: counter width in bits; must be at least 2.
- SEED, derived: reset/recovery pattern; MSB set, all other bits clear (4'b1000 at WIDTH=4). It is a legal state in both modes.
- PW, derived: $clog2(2*WIDTH), the width of pos.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- cnt_en  input  1  advance one step per cycle when high.
- johnson  input  1  0 = ring mode, 1 = Johnson mode; sampled every cycle.
- dir  input  1  0 = shift toward bit 0 (right), 1 = shift toward MSB (left).
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value written on load.
- count  output  WIDTH  registered counter state.
- wrap  output  1  registered one-cycle pulse; count has just returned to SEED by a normal step.
- err  output  1  registered one-cycle pulse; an illegal state was corrected on this edge.
- legal  output  1  combinational; count is a legal state for the current mode.
- pos  output  PW  combinational step index of count relative to SEED.

## Operation
- Priority at each edge: rst, then load, then cnt_en, otherwise hold.
- On rst: count becomes SEED, and wrap and err become 0.
- On load: count becomes load_val without a legality check. wrap and err become 0.
- On cnt_en with legal=0: count becomes SEED, err=1, wrap=0. No shift happens on that edge.
- On cnt_en with legal=1, a normal step:
  - dir=0: count[i] takes count[i+1], and count[WIDTH-1] takes fb. fb is count[0] in ring mode and ~count[0] in Johnson mode.
  - dir=1: count[i] takes count[i-1], and count[0] takes fb. fb is count[WIDTH-1] in ring mode and ~count[WIDTH-1] in Johnson mode.
  - wrap=1 if the new count equals SEED; err=0.
- On hold (no rst, load or cnt_en): count is unchanged, and wrap and err are 0.
- Legality:
  - Ring mode: exactly one bit set.
  - Johnson mode: at most one adjacent-bit transition (count[i] differs from count[i+1]), which gives exactly 2·WIDTH legal states.
- pos when legal:
  - Ring mode: WIDTH-1 minus the index of the set bit.
  - Johnson mode with count[WIDTH-1]=1: number of ones minus 1.
  - Johnson mode with count[WIDTH-1]=0: 2·WIDTH-1 minus the number of ones.
- pos is 0 when legal=0.
- Changing johnson mid-count: no immediate effect. If count is illegal in the new mode, the next enabled step corrects it.
- Changing dir mid-count takes effect on the next step with no correction; the sequence simply reverses.

## Timing
- Latency from cnt_en, load or rst to a count change is one edge.
- wrap and err are asserted in the same cycle as the count value they describe.
- legal and pos are combinational from count and johnson, with no extra latency.
- Ring period is WIDTH enabled steps; Johnson period is 2·WIDTH enabled steps.
- Illegal-state recovery completes in exactly one enabled step.
- rst asserted mid-operation overrides any load or cnt_en in the same cycle.

## Structure
- Shared package param_shift_ring_cntr_pkg holds:
  - constants MODE_RING=0, MODE_JOHNSON=1, DIR_RIGHT=0, DIR_LEFT=1;
  - function seed(WIDTH);
  - function pos_width(WIDTH).
- One combinational sub-module, ring_state_decode (parameter WIDTH), computes legal and pos from count and johnson. The top level uses legal for the correction decision.

## Test plan
- WIDTH=4, ring, dir=0, cnt_en=1 for 4 cycles after rst -> count 0100, 0010, 0001, 1000; pos 1, 2, 3, 0; wrap=1 only with the final 1000.
- Johnson, dir=0, 8 enabled cycles from SEED -> count 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000; pos 1..7, then 0; wrap on the 8th step only.
- Ring at 1000, dir=1 -> 0001, then 0010. Then drop cnt_en for 3 cycles -> count holds 0010, and wrap and err stay 0.
- Ring, load=1 and cnt_en=1 with load_val=0110 -> count=0110 (load wins), legal=0. On the next enabled cycle -> count=1000, err=1, wrap=0.
- Johnson at 1100, switch johnson=0 -> legal=0 immediately. On the next enabled cycle -> count=1000, err=1. On the following cycle -> count=0100, err=0.
- Mid-sequence, assert rst together with load=1 (load_val=0011) and cnt_en=1 -> count=1000, wrap=0, err=0 on the next edge.

Source files
------------

// File: rtl/param_shift_ring_cntr_pkg.sv
// Shared constants and sizing helpers for the parametrised ring/Johnson counter.
package param_shift_ring_cntr_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_RIGHT    = 1'b0;
    localparam logic DIR_LEFT     = 1'b1;

    // Reset/recovery pattern: only the MSB set; callers keep the low WIDTH bits.
    function automatic logic [63:0] seed(input int width);
        logic [63:0] s;
        s = 64'd0;
        s[width-1] = 1'b1;
        return s;
    endfunction

    function automatic int pos_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/param_shift_ring_cntr_decode.sv
// Combinational legality check and step-index decode for ring and Johnson states.
module ring_state_decode
    import param_shift_ring_cntr_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = pos_width(WIDTH)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             johnson,
    output logic             legal,
    output logic [PW-1:0]    pos
);

    logic [PW-1:0] ones_s;
    logic [PW-1:0] trans_s;
    logic [PW-1:0] idx_s;

    // Population count, highest set-bit index and adjacent-bit transition count.
    always_comb begin
        ones_s  = '0;
        trans_s = '0;
        idx_s   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_s = ones_s + PW'(count[i]);
            idx_s  = count[i] ? PW'(i) : idx_s;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            trans_s = trans_s + PW'(count[i] ^ count[i+1]);
        end
    end

    // Mode-dependent legality and position relative to the seed pattern.
    always_comb begin
        legal = 1'b0;
        pos   = '0;
        if (johnson == MODE_JOHNSON) begin
            legal = (trans_s <= PW'(1));
            if (!legal) begin
                pos = '0;
            end else if (count[WIDTH-1]) begin
                pos = ones_s - PW'(1);
            end else begin
                pos = PW'(2 * WIDTH - 1) - ones_s;
            end
        end else begin
            legal = (ones_s == PW'(1));
            pos   = legal ? (PW'(WIDTH - 1) - idx_s) : '0;
        end
    end

endmodule

// File: rtl/param_shift_ring_cntr.sv
// Ring/Johnson shift counter with parallel load, bidirectional shift and
// one-step recovery from illegal states.
module param_shift_ring_cntr
    import param_shift_ring_cntr_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = pos_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             johnson,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err,
    output logic             legal,
    output logic [PW-1:0]    pos
);

    localparam logic [63:0]      SEED_W = seed(WIDTH);
    localparam logic [WIDTH-1:0] SEED   = SEED_W[WIDTH-1:0];

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic             err_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    logic             err_nxt_s;
    logic [WIDTH-1:0] shifted_s;
    logic             legal_s;

    ring_state_decode #(.WIDTH(WIDTH)) u_decode (
        .count   (count_r),
        .johnson (johnson),
        .legal   (legal_s),
        .pos     (pos)
    );

    // One shift step; Johnson mode inverts the bit wrapping around.
    always_comb begin
        shifted_s = count_r;
        if (dir == DIR_LEFT) begin
            shifted_s = {count_r[WIDTH-2:0], count_r[WIDTH-1] ^ johnson};
        end else begin
            shifted_s = {count_r[0] ^ johnson, count_r[WIDTH-1:1]};
        end
    end

    // Next-state selection: load, then enabled step or correction, else hold.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        if (load) begin
            count_nxt_s = load_val;
        end else if (cnt_en) begin
            if (legal_s) begin
                count_nxt_s = shifted_s;
                wrap_nxt_s  = (shifted_s == SEED);
            end else begin
                count_nxt_s = SEED;
                err_nxt_s   = 1'b1;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State and status pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= SEED;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign err   = err_r;
    assign legal = legal_s;

endmodule
